// File: rtl/pulse_code_generator.sv
// ----------------------------------------------------------------------------
// pulse_code_generator
//
// Phase-code generator for the HFSWR transmitter chain. A rising edge of the
// pulse gate `sinc` latches a code, its length and a chip width. The code is
// then serialised LSB-first, with each bit held for `tiempo_b` clocks. The
// block supports alternating complementary A/B codes, continuous repeat while
// the gate is high, and a sticky flag for invalid configurations.
//
// Parameters:
//   CODE_W   code register width and maximum code length (1..255)
//   CNT_W    width of the chip-width counter and of tiempo_b
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   sinc       in   pulse gate; rising edge starts, low level ends/aborts
//   num_dig    in   code length in bits (sampled at start)
//   codigo_a   in   code A, bit 0 first (sampled at start)
//   codigo_b   in   code B, complementary partner (sampled at start)
//   tiempo_b   in   chip width in clocks (sampled at start)
//   modo       in   00 single A, 01 alternate A/B, 10 repeat A, 11 as 00
//   out        out  current code bit, 0 when idle
//   out_en     out  high while a code bit is driven
//   bit_idx    out  index of the bit currently on out
//   code_sel   out  code in use (0 = A, 1 = B), latched at start
//   busy       out  high while in RUN
//   done       out  one-cycle pulse when a code completes
//   aborted    out  one-cycle pulse when sinc falls during RUN
//   cfg_err    out  sticky invalid-configuration flag
// ----------------------------------------------------------------------------
module pulse_code_generator #(
    parameter int unsigned CODE_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sinc,
    input  logic [7:0]        num_dig,
    input  logic [CODE_W-1:0] codigo_a,
    input  logic [CODE_W-1:0] codigo_b,
    input  logic [CNT_W-1:0]  tiempo_b,
    input  logic [1:0]        modo,
    output logic              out,
    output logic              out_en,
    output logic [7:0]        bit_idx,
    output logic              code_sel,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWaitLow
    } state_e;

    localparam logic [8:0]       MaxLen = 9'(CODE_W);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e            state_q;
    logic              sinc_q;
    logic              toggle_q;
    logic              repeat_q;
    logic [CODE_W-1:0] code_q;
    logic [7:0]        len_q;
    logic [CNT_W-1:0]  chip_w_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              start;
    logic              cfg_ok;
    logic              sel_b;
    logic [CODE_W-1:0] start_code;
    logic              chip_last;
    logic              code_last;
    logic [7:0]        next_idx;
    logic [CODE_W-1:0] code_shift;
    logic              next_bit;

    always_comb begin
        start      = sinc & ~sinc_q;
        cfg_ok     = (num_dig != 8'd0) && ({1'b0, num_dig} <= MaxLen) && (tiempo_b != '0);
        // Only mode 01 ever selects code B; the toggle picks which one.
        sel_b      = (modo == 2'b01) & toggle_q;
        start_code = sel_b ? codigo_b : codigo_a;
        chip_last  = (cnt_q == chip_w_q - CntOne);
        code_last  = (bit_idx == len_q - 8'd1);
        next_idx   = bit_idx + 8'd1;
        // Shift instead of a variable bit-select so the index width never
        // has to match CODE_W.
        code_shift = code_q >> next_idx;
        next_bit   = code_shift[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            sinc_q   <= 1'b0;
            toggle_q <= 1'b0;
            repeat_q <= 1'b0;
            code_q   <= '0;
            len_q    <= '0;
            chip_w_q <= '0;
            cnt_q    <= '0;
            out      <= 1'b0;
            out_en   <= 1'b0;
            bit_idx  <= '0;
            code_sel <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            sinc_q  <= sinc;
            done    <= 1'b0;
            aborted <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_ok) begin
                            code_q   <= start_code;
                            len_q    <= num_dig;
                            chip_w_q <= tiempo_b;
                            repeat_q <= (modo == 2'b10);
                            cnt_q    <= '0;
                            bit_idx  <= '0;
                            code_sel <= sel_b;
                            out      <= start_code[0];
                            out_en   <= 1'b1;
                            busy     <= 1'b1;
                            cfg_err  <= 1'b0;
                            // Toggle advances on every started pulse,
                            // aborted ones included.
                            if (modo == 2'b01) begin
                                toggle_q <= ~toggle_q;
                            end
                            state_q  <= StRun;
                        end else begin
                            cfg_err <= 1'b1;
                            state_q <= StWaitLow;
                        end
                    end
                end

                StRun: begin
                    // Gate low wins over a terminal chip in the same cycle.
                    if (!sinc) begin
                        out     <= 1'b0;
                        out_en  <= 1'b0;
                        busy    <= 1'b0;
                        bit_idx <= '0;
                        cnt_q   <= '0;
                        aborted <= 1'b1;
                        state_q <= StIdle;
                    end else if (chip_last) begin
                        cnt_q <= '0;
                        if (!code_last) begin
                            bit_idx <= next_idx;
                            out     <= next_bit;
                        end else if (repeat_q) begin
                            // Wrap straight back to bit 0 with no gap cycle.
                            bit_idx <= '0;
                            out     <= code_q[0];
                            done    <= 1'b1;
                        end else begin
                            out     <= 1'b0;
                            out_en  <= 1'b0;
                            busy    <= 1'b0;
                            bit_idx <= '0;
                            done    <= 1'b1;
                            state_q <= StWaitLow;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end

                StWaitLow: begin
                    // One gate-high period yields at most one single code.
                    if (!sinc) begin
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/pulse_code_generator.md
# pulse_code_generator

Parametrised phase-code generator for the HFSWR transmitter chain. On each rising edge of the pulse gate `sinc` it latches a code, a code length and a chip width. It then serialises the code LSB-first, holding each bit for a programmable number of clocks. It supports codes wider than 32 bits, alternating complementary (A/B) code pairs, and continuous repeat, and flags invalid configurations. It feeds the BPSK modulator and reports pulse completion to the pulse sequencer.

## Interface
Parameters:
- `CODE_W`, 64: code register width and maximum code length; legal range 1..255.
- `CNT_W`, 32: width of the chip-width counter and `tiempo_b`.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sinc`  in  1  pulse gate (level); its rising edge starts a pulse, and its low level aborts or ends one.
- `num_dig`  in  8  code length in bits, sampled only at pulse start.
- `codigo_a`  in  CODE_W  code A; bit 0 is transmitted first; sampled at start.
- `codigo_b`  in  CODE_W  code B (complementary partner); sampled at start.
- `tiempo_b`  in  CNT_W  chip width in clocks, sampled at start.
- `modo`  in  2  00 single code A; 01 alternate A/B per pulse; 10 repeat code A while `sinc` is high; 11 behaves as 00.
- `out`  out  1  current code bit; 0 when not transmitting.
- `out_en`  out  1  high while a code bit is being driven.
- `bit_idx`  out  8  index of the bit currently on `out`.
- `code_sel`  out  1  code in use (0 = A, 1 = B), latched at start.
- `busy`  out  1  high in the RUN state.
- `done`  out  1  one-cycle pulse when a code completes normally.
- `aborted`  out  1  one-cycle pulse when `sinc` falls during RUN.
- `cfg_err`  out  1  sticky flag for an invalid configuration at start.

## Operation
- Reset: every output and internal register is 0. The FSM enters IDLE, and the A/B toggle is set to 0 (A first).
- Edge detect: `sinc_d` is a registered copy of `sinc`. A start is `sinc & ~sinc_d`, evaluated only in IDLE.
- FSM states: IDLE, RUN, WAIT_LOW.
- IDLE with a start and a valid configuration:
  - Shadow `num_dig`, `tiempo_b`, and the selected code into internal registers. Later input changes have no effect on the pulse.
  - Set `cfg_err`=0, `code_sel` = toggle (mode 01) or 0 (other modes), `bit_idx`=0, chip counter=0.
  - Drive `out`=code[0] and `out_en`=1, then go to RUN.
  - In mode 01, flip the toggle. The toggle advances on every started pulse, including pulses that are later aborted.
- Valid configuration: 1 ≤ `num_dig` ≤ CODE_W and `tiempo_b` ≠ 0.
- IDLE with a start and an invalid configuration: set `cfg_err`=1, leave the outputs idle, go to WAIT_LOW. The toggle does not change.
- RUN, each cycle while `sinc`=1:
  - When chip counter = `tiempo_b`−1: reset the counter to 0.
    - If `bit_idx` < n−1: increment `bit_idx` and drive the next bit.
    - If `bit_idx` = n−1 in modes 00/01/11: `out`=0, `out_en`=0, `done`=1 for one cycle, go to WAIT_LOW.
    - If `bit_idx` = n−1 in mode 10: wrap `bit_idx` to 0 and drive code[0] with no gap cycle. `done` pulses at each wrap.
  - Otherwise, increment the chip counter.
- RUN with `sinc`=0: `out`=0, `out_en`=0, `aborted`=1 for one cycle, no `done`, go to IDLE.
- If `sinc`=0 and the terminal chip occur in the same cycle, the abort wins: `aborted` pulses and `done` does not.
- WAIT_LOW: outputs stay idle. Go to IDLE when `sinc`=0, so one gate high period yields at most one code (modes 00/01).
- `busy` is high exactly in RUN.
- Counter arithmetic is unsigned CNT_W. `bit_idx` is 8-bit and never exceeds CODE_W−1.

## Timing
- Start latency: if the start is sampled at edge k, `out`=code[0] is valid from edge k (registered output, one cycle after `sinc` rises).
- Bit j occupies edges k+j·T through k+(j+1)·T−1, where T = latched `tiempo_b`.
- Total `out_en`-high time is n·T cycles.
- `done` is asserted at edge k+n·T, the same edge at which `out_en` falls.
- Abort: outputs clear one edge after `sinc` is sampled low.
- `rst` asserted mid-pulse clears all state immediately, with no `done` or `aborted` pulse.

## Test plan
- Mode 00, `codigo_a`=0x2D, `num_dig`=6, `tiempo_b`=3, `sinc` high 40 cycles → `out` = 1,0,1,1,0,1, each bit 3 cycles. `done` pulses at k+18; `out`=0 afterwards until `sinc` falls.
- Mode 01, A=0xB (4 bits), B=0x4, T=2, three pulses → `code_sel` = 0,1,0. The serial streams are 1101 / 0010 / 1101.
- Mode 10, A=0x5, n=3, T=1, `sinc` high 10 cycles → continuous 1,0,1,1,0,1,… with no gap. `done` pulses at every wrap. `sinc` low → `aborted` asserted and `out`=0 one edge later.
- CODE_W=64, n=64, A=0x8000_0000_0000_0001, T=1 → `out` high at bits 0 and 63 only. `bit_idx` reaches 63 and `done` pulses at k+64.
- Invalid configuration: `num_dig`=0, then `num_dig`=65 (CODE_W=64), then `tiempo_b`=0 → `cfg_err`=1 and `out_en` stays 0 each time. A following valid start clears `cfg_err`.
- Abort and reset: `sinc` drops at bit 2 → `aborted` for one cycle and no `done`. On a separate pulse, `rst` mid-bit → all outputs 0 immediately, toggle reset to A.
